// File: rtl/video_timing_meas.sv
// rtl/video_timing_meas.sv - HSYNC/VSYNC/DE timing analyser with stability lock for the scaler video output
module video_timing_meas #(
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int LOCK_FRAMES     = 3,
    parameter int HTIMEOUT        = 4095
) (
    input  logic        VCLK_i,
    input  logic        nRST_i,
    input  logic        HSYNC_i,
    input  logic        VSYNC_i,
    input  logic        DE_i,
    output logic [11:0] h_total_o,
    output logic [11:0] h_sync_o,
    output logic [11:0] h_active_o,
    output logic [10:0] v_total_o,
    output logic [10:0] v_active_o,
    output logic        meas_strobe_o,
    output logic        locked_o,
    output logic        h_unstable_o,
    output logic        lost_o
);
    localparam int            TW       = $clog2(HTIMEOUT + 2);
    localparam logic [TW-1:0] T_LIMIT  = TW'(HTIMEOUT + 1);
    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [3:0]    LOCK_MAX = 4'(LOCK_FRAMES);
    localparam logic [3:0]    LOCK_ARM = 4'(LOCK_FRAMES - 1);

    typedef enum logic {WAIT_V = 1'b0, MEAS = 1'b1} state_t;
    state_t state, state_nx;

    logic hs_r, vs_r, de_r, hs_d, vs_d, de_d;
    logic hs_lead, hs_trail, vs_lead, de_fall;

    logic [11:0]   hcnt, hsw, line_hsync, derun;
    logic [TW-1:0] tcnt;
    logic          h_valid, line_de;

    logic [11:0] last_len, ref_len, frame_hact;
    logic        ref_valid, unstable;
    logic [10:0] vcnt, vact;
    logic        pend;
    logic [3:0]  stable_cnt;

    logic [11:0] last_len_nx, ref_len_nx, frame_hact_nx;
    logic        ref_valid_nx, unstable_nx;
    logic [10:0] vcnt_nx, vact_nx;
    logic [3:0]  sc_inc;
    logic        lost_ev, upd, same;

    always_ff @(posedge VCLK_i) begin
        if (!nRST_i) begin
            {hs_r, vs_r, de_r, hs_d, vs_d, de_d} <= '0;
        end else begin
            hs_r <= HSYNC_i ^ SYNC_ACTIVE_LOW;
            vs_r <= VSYNC_i ^ SYNC_ACTIVE_LOW;
            de_r <= DE_i;
            hs_d <= hs_r;
            vs_d <= vs_r;
            de_d <= de_r;
        end
    end

    assign hs_lead  = hs_r & ~hs_d;
    assign hs_trail = ~hs_r & hs_d;
    assign vs_lead  = vs_r & ~vs_d;
    assign de_fall  = ~de_r & de_d;

    // The saturation terms are "about to overflow", so a sync edge arriving in time rescues the counter.
    assign lost_ev = (hcnt == 12'hFFF && !hs_lead)
                  || (derun == 12'hFFF && de_r && de_d)
                  || (tcnt == T_LIMIT && !hs_lead)
                  || (state == MEAS && vcnt == 11'h7FF && hs_lead);
    assign upd     = pend && !lost_ev;

    always_ff @(posedge VCLK_i) begin
        if (!nRST_i) begin
            state <= WAIT_V;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            WAIT_V:  if (vs_lead && !lost_ev) state_nx = MEAS;
            MEAS:    if (lost_ev) state_nx = WAIT_V;
            default: state_nx = WAIT_V;
        endcase
    end

    // Accumulators clear one cycle after the VSYNC edge, so a line closed by a coincident HSYNC edge lands in the old frame.
    always_comb begin
        if (state == WAIT_V || pend) begin
            last_len_nx   = '0;
            ref_len_nx    = '0;
            frame_hact_nx = '0;
            ref_valid_nx  = 1'b0;
            unstable_nx   = 1'b0;
            vcnt_nx       = '0;
            vact_nx       = '0;
        end else begin
            last_len_nx   = last_len;
            ref_len_nx    = ref_len;
            frame_hact_nx = frame_hact;
            ref_valid_nx  = ref_valid;
            unstable_nx   = unstable;
            vcnt_nx       = vcnt;
            vact_nx       = vact;
        end
        if (state == MEAS) begin
            if (hs_lead) begin
                if (vcnt_nx != 11'h7FF) vcnt_nx = vcnt_nx + 11'd1;
                if (line_de && vact_nx != 11'h7FF) vact_nx = vact_nx + 11'd1;
                if (h_valid) begin
                    last_len_nx = hcnt;
                    if (!ref_valid_nx) begin
                        ref_len_nx   = hcnt;
                        ref_valid_nx = 1'b1;
                    end else if (hcnt != ref_len_nx) begin
                        unstable_nx = 1'b1;
                    end
                end
            end
            if (de_fall && derun > frame_hact_nx) frame_hact_nx = derun;
        end
    end

    assign same   = ({last_len, line_hsync, frame_hact, vcnt, vact}
                  == {h_total_o, h_sync_o, h_active_o, v_total_o, v_active_o});
    assign sc_inc = (stable_cnt >= LOCK_MAX) ? LOCK_MAX : stable_cnt + 4'd1;

    always_ff @(posedge VCLK_i) begin
        if (!nRST_i) begin
            hcnt       <= '0;
            tcnt       <= '0;
            hsw        <= '0;
            line_hsync <= '0;
            derun      <= '0;
            h_valid    <= 1'b0;
            line_de    <= 1'b0;
            last_len   <= '0;
            ref_len    <= '0;
            frame_hact <= '0;
            ref_valid  <= 1'b0;
            unstable   <= 1'b0;
            vcnt       <= '0;
            vact       <= '0;
            pend       <= 1'b0;
            stable_cnt <= '0;
        end else begin
            hcnt    <= hs_lead ? 12'd1 : ((hcnt == 12'hFFF) ? hcnt : hcnt + 12'd1);
            tcnt    <= hs_lead ? '0 : ((tcnt == T_LIMIT) ? tcnt : tcnt + T_ONE);
            h_valid <= lost_ev ? 1'b0 : (hs_lead ? 1'b1 : h_valid);
            line_de <= hs_lead ? de_r : (line_de | de_r);
            if (hs_r) hsw <= hs_lead ? 12'd1 : ((hsw == 12'hFFF) ? hsw : hsw + 12'd1);
            if (hs_trail) line_hsync <= hsw;
            if (!de_r) derun <= '0;
            else derun <= !de_d ? 12'd1 : ((derun == 12'hFFF) ? derun : derun + 12'd1);

            last_len   <= last_len_nx;
            ref_len    <= ref_len_nx;
            frame_hact <= frame_hact_nx;
            ref_valid  <= ref_valid_nx;
            unstable   <= unstable_nx;
            vcnt       <= vcnt_nx;
            vact       <= vact_nx;
            pend       <= (state == MEAS) && vs_lead && !lost_ev;

            if (lost_ev) begin
                stable_cnt <= '0;
            end else if (upd) begin
                stable_cnt <= (same && !unstable) ? sc_inc : 4'd0;
            end
        end
    end

    always_ff @(posedge VCLK_i) begin
        if (!nRST_i) begin
            h_total_o     <= '0;
            h_sync_o      <= '0;
            h_active_o    <= '0;
            v_total_o     <= '0;
            v_active_o    <= '0;
            meas_strobe_o <= 1'b0;
            locked_o      <= 1'b0;
            h_unstable_o  <= 1'b0;
            lost_o        <= 1'b0;
        end else begin
            meas_strobe_o <= upd;
            if (upd) begin
                h_total_o    <= last_len;
                h_sync_o     <= line_hsync;
                h_active_o   <= frame_hact;
                v_total_o    <= vcnt;
                v_active_o   <= vact;
                h_unstable_o <= unstable;
            end
            if (lost_ev) begin
                lost_o   <= 1'b1;
                locked_o <= 1'b0;
            end else if (upd) begin
                lost_o   <= 1'b0;
                locked_o <= same && !unstable && (sc_inc >= LOCK_ARM);
            end
        end
    end
endmodule

// File: tb/tb_video_timing_meas.sv
// tb/tb_video_timing_meas.sv - directed bench for video_timing_meas using scaled-down video modes
module tb_video_timing_meas;
    logic        vclk = 1'b0;
    logic        nrst;
    logic        hsync, vsync, de;
    logic [11:0] h_total, h_sync, h_active;
    logic [10:0] v_total, v_active;
    logic        meas_strobe, locked, h_unstable, lost;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int vs_at       = 0;
    int strobe_at   = 0;
    int n_strobe    = 0;
    int ns_saved    = 0;
    bit vs_prev     = 1'b0;

    logic [11:0] s_htot, s_hsync, s_hact;
    logic [10:0] s_vtot, s_vact;
    logic        s_lock, s_unst, s_lost;

    video_timing_meas dut (
        .VCLK_i        (vclk),
        .nRST_i        (nrst),
        .HSYNC_i       (hsync),
        .VSYNC_i       (vsync),
        .DE_i          (de),
        .h_total_o     (h_total),
        .h_sync_o      (h_sync),
        .h_active_o    (h_active),
        .v_total_o     (v_total),
        .v_active_o    (v_active),
        .meas_strobe_o (meas_strobe),
        .locked_o      (locked),
        .h_unstable_o  (h_unstable),
        .lost_o        (lost)
    );

    always #5 vclk = ~vclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Syncs are driven active-low; the "asserted" arguments are logical levels.
    task automatic tick(input bit hs_a, input bit vs_a, input bit de_v);
        hsync = ~hs_a;
        vsync = ~vs_a;
        de    = de_v;
        if (vs_a && !vs_prev) vs_at = cyc;
        vs_prev = vs_a;
        @(posedge vclk);
        #1;
        cyc++;
        if (meas_strobe) begin
            n_strobe++;
            strobe_at = cyc;
            s_htot  = h_total;
            s_hsync = h_sync;
            s_hact  = h_active;
            s_vtot  = v_total;
            s_vact  = v_active;
            s_lock  = locked;
            s_unst  = h_unstable;
            s_lost  = lost;
        end
    endtask

    task automatic drive_line(input int len, input int hsw, input int hact, input bit act, input bit vs_a);
        for (int c = 0; c < len; c++)
            tick(c < hsw, vs_a, act && c >= hsw + 2 && c < hsw + 2 + hact);
    endtask

    // VSYNC asserts on line 0 together with HSYNC; active lines start at line 3.
    task automatic gen_frame(input int htot, input int hsw, input int hact, input int vtot,
                             input int vact, input int short_line, input int short_len);
        for (int l = 0; l < vtot; l++)
            drive_line((l == short_line) ? short_len : htot, hsw, hact, l >= 3 && l < 3 + vact, l < 2);
    endtask

    task automatic chk_frame(input string tag, input int htot, input int hsw, input int hact,
                             input int vtot, input int vact);
        chk({tag, ".h_total"},  32'(s_htot),  32'(htot));
        chk({tag, ".h_sync"},   32'(s_hsync), 32'(hsw));
        chk({tag, ".h_active"}, 32'(s_hact),  32'(hact));
        chk({tag, ".v_total"},  32'(s_vtot),  32'(vtot));
        chk({tag, ".v_active"}, 32'(s_vact),  32'(vact));
    endtask

    task automatic frame_a();
        gen_frame(30, 4, 20, 10, 7, -1, 0);
    endtask

    task automatic frame_b(input int short_line);
        gen_frame(40, 6, 28, 12, 9, short_line, 39);
    endtask

    initial begin
        nrst  = 1'b0;
        hsync = 1'b1;
        vsync = 1'b1;
        de    = 1'b0;
        for (int i = 0; i < 3; i++) tick(0, 0, 0);
        chk("rst.h_total", 32'(h_total), 0);
        chk("rst.v_total", 32'(v_total), 0);
        chk("rst.strobe", 32'(meas_strobe), 0);
        chk("rst.locked", 32'(locked), 0);
        chk("rst.lost", 32'(lost), 0);
        nrst = 1'b1;
        for (int i = 0; i < 5; i++) tick(0, 0, 0);

        // Mode A: 30/4/20/10/7
        frame_a();
        chk("a0.no_strobe", 32'(n_strobe), 0);
        frame_a();
        chk("a1.count", 32'(n_strobe), 1);
        chk("a1.latency", 32'(strobe_at - vs_at), 3);
        chk_frame("a1", 30, 4, 20, 10, 7);
        chk("a1.locked", 32'(s_lock), 0);
        chk("a1.unstable", 32'(s_unst), 0);
        frame_a();
        chk("a2.locked", 32'(s_lock), 0);
        frame_a();
        chk("a3.count", 32'(n_strobe), 3);
        chk("a3.locked", 32'(s_lock), 1);
        chk_frame("a3", 30, 4, 20, 10, 7);

        // Mode B: 40/6/28/12/9
        frame_b(-1);
        chk("b0.h_total", 32'(s_htot), 30);
        chk("b0.locked", 32'(s_lock), 1);
        frame_b(-1);
        chk_frame("b1", 40, 6, 28, 12, 9);
        chk("b1.locked", 32'(s_lock), 0);
        chk("b1.latency", 32'(strobe_at - vs_at), 3);
        frame_b(-1);
        chk("b2.locked", 32'(s_lock), 0);
        frame_b(-1);
        chk("b3.locked", 32'(s_lock), 1);
        chk("b3.lost", 32'(s_lost), 0);

        // HSYNC stops
        for (int i = 0; i < 4000; i++) tick(0, 0, 0);
        chk("to.early_lost", 32'(lost), 0);
        for (int i = 0; i < 200; i++) tick(0, 0, 0);
        chk("to.lost", 32'(lost), 1);
        chk("to.locked", 32'(locked), 0);
        chk("to.h_total_hold", 32'(h_total), 40);
        chk("to.v_total_hold", 32'(v_total), 12);
        chk("to.h_active_hold", 32'(h_active), 28);
        ns_saved = n_strobe;
        frame_b(-1);
        chk("r0.no_strobe", 32'(n_strobe), 32'(ns_saved));
        chk("r0.lost_held", 32'(lost), 1);
        frame_b(-1);
        chk("r1.lost", 32'(s_lost), 0);
        chk("r1.locked", 32'(s_lock), 0);
        chk_frame("r1", 40, 6, 28, 12, 9);
        frame_b(-1);
        chk("r2.locked", 32'(s_lock), 1);

        // One 39-pixel line inside a 40-pixel frame
        frame_b(5);
        frame_b(-1);
        chk("u.unstable", 32'(s_unst), 1);
        chk("u.locked", 32'(s_lock), 0);
        chk("u.h_total", 32'(s_htot), 40);
        frame_b(-1);
        chk("c1.unstable", 32'(s_unst), 0);
        chk("c1.locked", 32'(s_lock), 0);
        frame_b(-1);
        frame_b(-1);
        chk("c3.locked", 32'(s_lock), 1);

        // Mid-frame reset while locked
        chk("pre_rst.locked", 32'(locked), 1);
        for (int l = 0; l < 5; l++) drive_line(40, 6, 28, l >= 3, l < 2);
        nrst = 1'b0;
        tick(0, 0, 0);
        nrst = 1'b1;
        chk("mrst.h_total", 32'(h_total), 0);
        chk("mrst.v_total", 32'(v_total), 0);
        chk("mrst.h_active", 32'(h_active), 0);
        chk("mrst.locked", 32'(locked), 0);
        chk("mrst.lost", 32'(lost), 0);
        for (int l = 5; l < 12; l++) drive_line(40, 6, 28, 1'b1, 1'b0);
        ns_saved = n_strobe;
        frame_b(-1);
        chk("n0.no_strobe", 32'(n_strobe), 32'(ns_saved));
        frame_b(-1);
        chk("n1.count", 32'(n_strobe), 32'(ns_saved + 1));
        chk_frame("n1", 40, 6, 28, 12, 9);
        chk("n1.locked", 32'(s_lock), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
